ahb_lite_cmd_master: RTL and testbench
======================================

Name: ahb_lite_cmd_master

Overview:
Synthesizable AHB-lite master that sits directly upstream of ahb_slave and drives its htrans/hwrite/haddr/hwdata inputs. It accepts simple single-beat read and write commands on a valid/ready interface and buffers them in a small FIFO. It issues them as NONSEQ transfers with a correctly pipelined address and data phase, honouring hready wait states. Read data is returned on a one-cycle response strobe.

Parameters:
ADDR_W, 8, haddr and cmd_addr width
DATA_W, 32, hwdata, hrdata, cmd_wdata and rsp_rdata width
FIFO_DEPTH, 4, command FIFO entries; power of 2, >= 2

Ports:
hclk  in  1  clock; all state updates on rising edge
hresetn  in  1  asynchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept; combinational, = !fifo_full
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  transfer address
cmd_wdata  in  DATA_W  write data (ignored for reads)
hready  in  1  slave ready; a bus phase completes on an edge with hready=1
hrdata  in  DATA_W  slave read data, valid in the data phase
htrans  out  2  2'b00 IDLE, 2'b10 NONSEQ; no other codes are generated
hwrite  out  1  address-phase direction
haddr  out  ADDR_W  address-phase address
hwdata  out  DATA_W  data-phase write data
rsp_valid  out  1  one-cycle pulse: read data phase completed
rsp_rdata  out  DATA_W  captured hrdata, valid with rsp_valid
busy  out  1  FIFO non-empty, OR address phase NONSEQ, OR data phase pending

Behaviour:
- Clock and reset: one clock, hclk. Reset is asynchronous and active-low on hresetn.
- While hresetn=0:
  - htrans=0, hwrite=0, haddr=0, hwdata=0, rsp_valid=0, rsp_rdata=0, busy=0.
  - FIFO is emptied and the data-phase valid flag is cleared.
  - cmd_ready=1, but pushes are ignored while in reset.
- Reset mid-operation: all queued and in-flight transfers are discarded and no rsp_valid is produced for them.
- Push: occurs on an edge where cmd_valid && cmd_ready. It stores {write, addr, wdata}.
- Full: cmd_ready=0 when the FIFO is full, even if a pop occurs in the same cycle; there is no push-through when full.
- Pipeline advance: happens only on an edge where hready=1. On such an edge, both steps below occur together.
  - Address-phase register → data-phase register: if the address phase was NONSEQ, set data-phase valid. If it was also a write, load hwdata with its wdata. Otherwise clear data-phase valid; hwdata holds its previous value.
  - FIFO → address-phase register:
    - If the FIFO is non-empty, pop the head: htrans=NONSEQ, haddr=addr, hwrite=write.
    - If the FIFO is empty: htrans=IDLE, hwrite=0, haddr=0.
- Read response: if the data phase completing on this edge was a read, rsp_valid=1 for the next cycle and rsp_rdata=hrdata sampled at this edge. rsp_rdata holds its value after the pulse.
- hready=0 at an edge:
  - htrans, haddr, hwrite and hwdata all hold; no pop occurs; rsp_valid=0.
  - FIFO pushes still occur.
- Latency with hready=1 and the FIFO empty:
  - Command accepted at edge N.
  - Address phase is driven between edges N+1 and N+2.
  - hwdata is driven between edges N+2 and N+3.
  - For a read, rsp_valid is high after edge N+3.
- Throughput: back-to-back commands with hready=1 give one NONSEQ per cycle with no IDLE gaps. hwdata trails haddr by exactly one cycle.
- Simultaneous push and pop when not full: both take effect, so the occupancy count is unchanged.
- Not supported: hresp (treated as OKAY), bursts and hsize. There is no SEQ or BUSY output.

Test Plan:
- Reset, then 3 idle cycles with hready=1 → htrans=0, haddr=0, hwrite=0, hwdata=0, cmd_ready=1, busy=0, rsp_valid=0.
- Single write addr=0x0d data=0x5a5a5a5a accepted at edge 0, hready=1 → after edge 1: htrans=2, haddr=0x0d, hwrite=1; after edge 2: htrans=0, hwdata=0x5a5a5a5a; busy=0 after edge 3.
- Back-to-back writes i=0..3 with addr=0x99-i, data=0xfff-i, one per cycle → four consecutive NONSEQ cycles with haddr 0x99,0x98,0x97,0x96; hwdata 0xfff..0xffc each one cycle later; no IDLE gaps.
- Write 0x05/0x55 followed by write 0x04/0x44; hready=0 for 3 cycles during the first data phase → haddr=0x04 and hwdata=0x55 held for 3 cycles; second transfer completes after hready returns to 1.
- Read addr=0x20; slave drives hrdata=0xdeadbeef in the data phase → rsp_valid high for exactly 1 cycle with rsp_rdata=0xdeadbeef; hwdata unchanged.
- hready held 0; push 5 commands on consecutive cycles → cmd_ready=0 after the 4th push and the 5th is not accepted. Set hready=1 → cmd_ready=1 one cycle later. Assert hresetn=0 mid-drain → outputs zero immediately and no further NONSEQ after release.

Source files
------------

// File: rtl/ahb_lite_cmd_master.sv
// AHB-lite single-beat command master: buffers read/write commands in a FIFO and
// issues them as NONSEQ transfers with a pipelined address and data phase.
module ahb_lite_cmd_master #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              hclk,
    input  logic              hresetn,
    // cmd handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready depends only on FIFO occupancy, never on cmd_valid or hready.
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic              hready,
    input  logic [DATA_W-1:0] hrdata,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [ADDR_W-1:0] haddr,
    output logic [DATA_W-1:0] hwdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ENT_W = 1 + ADDR_W + DATA_W;
    localparam logic [PTR_W:0] DEPTH_CNT = FIFO_DEPTH[PTR_W:0];
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  head;
    logic [DATA_W-1:0] ap_wdata;
    logic              dp_valid;
    logic              dp_write;
    logic              ap_nonseq;

    assign fifo_full  = (count == DEPTH_CNT);
    assign fifo_empty = (count == '0);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign pop        = hready && !fifo_empty;
    assign head       = fifo_mem[rd_ptr];
    assign ap_nonseq  = (htrans == HTRANS_NONSEQ);
    assign busy       = !fifo_empty || ap_nonseq || dp_valid;

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge hclk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Address and data phases advance together, only on edges with hready=1.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            htrans    <= HTRANS_IDLE;
            hwrite    <= 1'b0;
            haddr     <= '0;
            ap_wdata  <= '0;
            hwdata    <= '0;
            dp_valid  <= 1'b0;
            dp_write  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else if (hready) begin
            dp_valid <= ap_nonseq;
            dp_write <= hwrite;
            if (ap_nonseq && hwrite) begin
                hwdata <= ap_wdata;
            end
            rsp_valid <= dp_valid && !dp_write;
            if (dp_valid && !dp_write) begin
                rsp_rdata <= hrdata;
            end
            if (!fifo_empty) begin
                htrans   <= HTRANS_NONSEQ;
                hwrite   <= head[ENT_W-1];
                haddr    <= head[DATA_W +: ADDR_W];
                ap_wdata <= head[DATA_W-1:0];
            end else begin
                htrans <= HTRANS_IDLE;
                hwrite <= 1'b0;
                haddr  <= '0;
            end
        end else begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Directed bench for ahb_lite_cmd_master: cycle-exact checks in the main flow plus a
// bus monitor that checks every completed transfer against expected queues.
module tb_ahb_lite_cmd_master;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              hclk = 1'b0;
    logic              hresetn;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              hready;
    logic [DATA_W-1:0] hrdata;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [ADDR_W-1:0] haddr;
    logic [DATA_W-1:0] hwdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W:0]   exp_addr_q[$];
    logic [DATA_W-1:0] exp_wdata_q[$];
    logic [DATA_W-1:0] exp_q[$];

    logic [ADDR_W-1:0] slave_dp_addr;
    logic              mon_dp_pend;
    logic              mon_dp_write;

    ahb_lite_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .hready(hready), .hrdata(hrdata),
        .htrans(htrans), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy)
    );

    // ---------------- clock / reset ----------------
    always #5 hclk = ~hclk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    // ---------------- slave read-data model ----------------
    function automatic logic [DATA_W-1:0] slave_rdata(input logic [ADDR_W-1:0] a);
        return (a == 8'h20) ? 32'hdeadbeef : {24'hc0ffee, a};
    endfunction

    always @(posedge hclk) begin
        if (hready) slave_dp_addr <= haddr;
    end
    assign hrdata = slave_rdata(slave_dp_addr);

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    // For reads, d carries the hand-computed read data expected back.
    task automatic send(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input bit accept);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        if (accept) begin
            exp_addr_q.push_back({w, a});
            if (w) exp_wdata_q.push_back(d);
            else   exp_q.push_back(d);
        end
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_htrans"}, 32'(htrans), 32'h0);
        chk({tag, "_haddr"}, 32'(haddr), 32'h0);
        chk({tag, "_hwrite"}, 32'(hwrite), 32'h0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge hclk) begin
        if (!hresetn) begin
            exp_addr_q.delete();
            exp_wdata_q.delete();
            exp_q.delete();
            mon_dp_pend  <= 1'b0;
            mon_dp_write <= 1'b0;
        end else begin
            if (htrans != 2'b00 && htrans != 2'b10) chk("htrans_code", 32'(htrans), 32'h2);
            if (hready) begin
                if (mon_dp_pend && mon_dp_write) begin
                    if (exp_wdata_q.size() == 0) chk("sb_hwdata_unexpected", hwdata, 32'hx);
                    else chk("sb_hwdata", hwdata, exp_wdata_q.pop_front());
                end
                if (htrans == 2'b10) begin
                    if (exp_addr_q.size() == 0) chk("sb_addr_unexpected", {23'h0, hwrite, haddr}, 32'hx);
                    else chk("sb_addr", {23'h0, hwrite, haddr}, {23'h0, exp_addr_q.pop_front()});
                    mon_dp_pend  <= 1'b1;
                    mon_dp_write <= hwrite;
                end else begin
                    mon_dp_pend <= 1'b0;
                end
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) chk("sb_rsp_unexpected", rsp_rdata, 32'hx);
                else chk("sb_rsp", rsp_rdata, exp_q.pop_front());
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [1:0]        b2b_htrans [6] = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
    logic [ADDR_W-1:0] b2b_haddr  [6] = '{8'h00, 8'h99, 8'h98, 8'h97, 8'h96, 8'h00};
    logic [DATA_W-1:0] b2b_hwdata [6] = '{32'h5a5a5a5a, 32'h5a5a5a5a, 32'hfff, 32'hffe, 32'hffd, 32'hffc};

    initial begin
        hresetn   = 1'b0;
        hready    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        #1;
        chk_idle_outputs("in_reset");
        tick(); tick(); tick();
        hresetn = 1'b1;

        // reset then idle cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle_outputs("idle");
            chk("idle_hwdata", hwdata, 32'h0);
        end

        // single write
        send(1'b1, 8'h0d, 32'h5a5a5a5a, 1'b1);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("sw_htrans", 32'(htrans), 32'h2);
        chk("sw_haddr", 32'(haddr), 32'h0d);
        chk("sw_hwrite", 32'(hwrite), 32'h1);
        chk("sw_hwdata_before", hwdata, 32'h0);
        tick();
        chk("sw_htrans_idle", 32'(htrans), 32'h0);
        chk("sw_hwdata", hwdata, 32'h5a5a5a5a);
        chk("sw_busy_dp", 32'(busy), 32'h1);
        tick();
        chk("sw_busy_done", 32'(busy), 32'h0);
        idle(2);

        // back-to-back writes, no IDLE gaps
        for (int k = 0; k < 6; k++) begin
            if (k < 4) send(1'b1, 8'(8'h99 - k), 32'(32'hfff - k), 1'b1);
            else cmd_valid = 1'b0;
            tick();
            chk($sformatf("b2b_htrans_%0d", k), 32'(htrans), 32'(b2b_htrans[k]));
            chk($sformatf("b2b_haddr_%0d", k), 32'(haddr), 32'(b2b_haddr[k]));
            chk($sformatf("b2b_hwdata_%0d", k), hwdata, b2b_hwdata[k]);
        end
        idle(3);

        // wait states during the first data phase
        send(1'b1, 8'h05, 32'h55, 1'b1);
        tick();
        send(1'b1, 8'h04, 32'h44, 1'b1);
        tick();
        cmd_valid = 1'b0;
        chk("ws_haddr_first", 32'(haddr), 32'h05);
        tick();
        chk("ws_haddr_second", 32'(haddr), 32'h04);
        chk("ws_hwdata_first", hwdata, 32'h55);
        hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("ws_hold_haddr_%0d", i), 32'(haddr), 32'h04);
            chk($sformatf("ws_hold_htrans_%0d", i), 32'(htrans), 32'h2);
            chk($sformatf("ws_hold_hwdata_%0d", i), hwdata, 32'h55);
        end
        hready = 1'b1;
        tick();
        chk("ws_htrans_after", 32'(htrans), 32'h0);
        chk("ws_hwdata_second", hwdata, 32'h44);
        tick();
        chk("ws_busy_done", 32'(busy), 32'h0);
        idle(2);

        // single read with one-cycle response pulse
        send(1'b0, 8'h20, 32'hdeadbeef, 1'b1);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("rd_htrans", 32'(htrans), 32'h2);
        chk("rd_hwrite", 32'(hwrite), 32'h0);
        tick();
        chk("rd_rsp_early", 32'(rsp_valid), 32'h0);
        tick();
        chk("rd_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("rd_rsp_rdata", rsp_rdata, 32'hdeadbeef);
        tick();
        chk("rd_rsp_pulse_end", 32'(rsp_valid), 32'h0);
        chk("rd_rsp_hold", rsp_rdata, 32'hdeadbeef);
        chk("rd_hwdata_unchanged", hwdata, 32'h44);
        idle(2);

        // mixed read/write stream, checked by the monitor
        send(1'b0, 8'h33, 32'hc0ffee33, 1'b1);
        tick();
        send(1'b1, 8'h34, 32'h0000abcd, 1'b1);
        tick();
        send(1'b0, 8'h35, 32'hc0ffee35, 1'b1);
        tick();
        idle(5);

        // fill FIFO while stalled, then reset mid-drain
        hready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send(1'b1, 8'(8'h40 + k), 32'(32'h1000 + k), k < 4);
            tick();
            chk($sformatf("full_cmd_ready_%0d", k), 32'(cmd_ready), (k >= 3) ? 32'h0 : 32'h1);
        end
        cmd_valid = 1'b0;
        hready = 1'b1;
        tick();
        chk("full_ready_back", 32'(cmd_ready), 32'h1);
        chk("full_drain_haddr0", 32'(haddr), 32'h40);
        tick();
        chk("full_drain_haddr1", 32'(haddr), 32'h41);
        hresetn = 1'b0;
        #1;
        chk_idle_outputs("mid_reset");
        chk("mid_reset_hwdata", hwdata, 32'h0);
        chk("mid_reset_rdata", rsp_rdata, 32'h0);
        tick(); tick();
        hresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("post_reset_htrans_%0d", i), 32'(htrans), 32'h0);
            chk($sformatf("post_reset_busy_%0d", i), 32'(busy), 32'h0);
        end

        // recovery traffic after reset
        send(1'b1, 8'h77, 32'h00001234, 1'b1);
        tick();
        send(1'b0, 8'h20, 32'hdeadbeef, 1'b1);
        tick();
        cmd_valid = 1'b0;

        begin
            int n;
            n = 0;
            while (busy && n < 20) begin
                tick();
                n++;
            end
            chk("drain_timeout", 32'(busy), 32'h0);
        end
        idle(3);
        chk("left_addr_q", 32'(exp_addr_q.size()), 32'h0);
        chk("left_wdata_q", 32'(exp_wdata_q.size()), 32'h0);
        chk("left_rsp_q", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
